transmitter: RTL and testbench



---
 rtl/tx_pkg.sv | 7 +
 rtl/tx_baud_counter.sv | 17 +
 rtl/transmitter.sv | 62 ++++++
 tb/tb_transmitter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// tx_pkg: shared FSM states and frame constants for the serial transmitter.
package tx_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/tx_baud_counter.sv
// tx_baud_counter: modulo-CLKS_PER_BIT bit timer with a synchronous clear and one-cycle bit_done.
module tx_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] count;
    assign bit_done = !clear && count == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (!reset || clear || bit_done) count <= '0;
        else count <= count + 1'b1;
    end
endmodule

// File: rtl/transmitter.sv
// transmitter: 8N1 serial transmitter with start strobe, registered tx and free flag.
module transmitter
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       tr_start,
    output logic       tr_free,
    output logic       tx
);
    state_t state, next_state;
    logic [7:0] shift, next_shift;
    logic [2:0] idx, next_idx;
    logic bit_done, next_tx;
    tx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
        .clk(clk),
        .reset(reset),
        .clear(state == IDLE),
        .bit_done(bit_done)
    );
    always_comb begin
        next_state = state;
        next_shift = shift;
        next_idx = idx;
        case (state)
            IDLE: if (tr_start) begin
                next_state = START;
                next_shift = din;
            end
            START: if (bit_done) begin
                next_state = DATA;
                next_idx = '0;
            end
            DATA: if (bit_done) begin
                next_shift = shift >> 1;
                next_idx = idx + 1'b1;
                next_state = idx == 3'(DATA_BITS - 1) ? STOP : DATA;
            end
            default: if (bit_done) next_state = IDLE;
        endcase
        // tx is computed from the next state so the registered line lines up with the state change
        next_tx = next_state == START ? 1'b0 : next_state == DATA ? next_shift[0] : IDLE_LEVEL;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            shift <= '0;
            idx <= '0;
            tx <= IDLE_LEVEL;
            tr_free <= 1'b1;
        end else begin
            state <= next_state;
            shift <= next_shift;
            idx <= next_idx;
            tx <= next_tx;
            tr_free <= next_state == IDLE;
        end
    end
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: randomized scoreboard bench against a frame-timeline reference model.
module tb_transmitter;
    localparam int N = 4;
    localparam int FRAME = 10 * N;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tr_start = 1'b0;
    logic [7:0] din = '0;
    logic tr_free, tx;
    logic reset2 = 1'b0;
    logic tr_start2 = 1'b0;
    logic [7:0] din2 = '0;
    logic tr_free2, tx2;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [1:0] exp_q[$];
    bit active = 0;
    int elapsed = 0;
    logic [7:0] mbyte = '0;

    always #5 clk = ~clk;

    transmitter #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .reset(reset), .din(din), .tr_start(tr_start), .tr_free(tr_free), .tx(tx)
    );
    transmitter dut2 (
        .clk(clk), .reset(reset2), .din(din2), .tr_start(tr_start2), .tr_free(tr_free2), .tx(tx2)
    );

    function automatic logic model_tx();
        int b = elapsed / N;
        if (!active) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return mbyte[b-1];
        return 1'b1;
    endfunction

    // one clock of stimulus; the model advances on the same edge and queues what the line must show afterwards
    task automatic step(input logic r, input logic s, input logic [7:0] d);
        @(negedge clk);
        reset = r;
        tr_start = s;
        din = d;
        @(posedge clk);
        cyc++;
        if (!r) active = 0;
        else if (active) begin
            elapsed++;
            if (elapsed == FRAME) active = 0;
        end else if (s) begin
            active = 1;
            elapsed = 0;
            mbyte = d;
        end
        exp_q.push_back({model_tx(), !active});
    endtask

    task automatic send(input logic [7:0] d);
        for (int i = 0; i < 2 * FRAME && active; i++) step(1, 0, 8'($urandom));
        step(1, 1, d);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            vectors++;
            if ({tx, tr_free} !== e) begin
                miscompares++;
                $display("FAIL line cyc=%0d tx=%b tr_free=%b expected tx=%b tr_free=%b", cyc, tx, tr_free, e[1], e[0]);
            end
        end
    end

    initial begin
        int n0, nf;
        bit seen_one;
        for (int i = 0; i < 10; i++) step(0, 1, 8'hA5);
        reset2 = 1'b1;
        step(1, 0, 8'h00);
        step(1, 1, 8'h61);
        for (int i = 0; i < 12; i++) step(1, 0, 8'h61);
        step(1, 1, 8'hFF);
        for (int i = 0; i < 10; i++) step(1, i % 3 == 0, 8'($urandom));
        send(8'h00);
        send(8'hFF);
        send(8'h55);
        for (int i = 0; i < 14; i++) step(1, 0, 8'h55);
        step(0, 1, 8'h55);
        step(1, 0, 8'h00);
        send(8'hA5);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0, 8'($urandom));
        for (int i = 0; i < FRAME + 2; i++) step(1, 0, 8'h00);
        @(negedge clk);
        tr_start2 = 1'b1;
        din2 = 8'h61;
        @(negedge clk);
        tr_start2 = 1'b0;
        din2 = 8'hFF;
        n0 = 0;
        nf = 0;
        seen_one = 0;
        while (!tr_free2 && nf < 20000) begin
            if (tx2) seen_one = 1;
            else if (!seen_one) n0++;
            nf++;
            @(negedge clk);
        end
        vectors++;
        if (n0 != 868) begin
            miscompares++;
            $display("FAIL default_start_bit cycles=%0d expected 868", n0);
        end
        vectors++;
        if (nf != 8680) begin
            miscompares++;
            $display("FAIL default_frame_len cycles=%0d expected 8680", nf);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
